// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - EX-stage ALU: op decode, valid/ready handshake, optional iterative MUL
//
// Purpose:
//   Decodes alu_op/funct7/funct3 into a 4-bit operation code and executes it on
//   XLEN-bit operands. The result, zero flag, operation and illegal flag are
//   registered and held until the consumer accepts them.
//   Optional feature macro: ALU_MUL_EN. When defined, funct7=0000001/funct3=000
//   is a low-word multiply run over XLEN cycles. Otherwise that encoding is illegal.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_valid   request valid
//   in_ready   unit can accept a request this cycle
//   alu_op     00 load/store, 01 branch, 10 R-type, 11 LUI
//   funct7     instruction funct7
//   funct3     instruction funct3
//   op_a       operand A
//   op_b       operand B / U-immediate
//   out_valid  result valid
//   out_ready  consumer accepts result
//   result     registered result
//   zero       result == 0, registered alongside result
//   operation  decoded op code of the held result
//   illegal    held request had an unrecognised R-type encoding

module alu_exec_unit #(
  parameter int XLEN = 32,
  localparam int SHW = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_op,
  input  logic [6:0]      funct7,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic [3:0]      operation,
  output logic            illegal
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DONE = 2'd2;
`ifdef ALU_MUL_EN
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [3:0] OP_MUL = 4'b1100;
`endif

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLL  = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_PASS = 4'b1000;
  localparam logic [3:0] OP_SLT  = 4'b1001;
  localparam logic [3:0] OP_SLTU = 4'b1010;

  logic [1:0]      state;
  logic [3:0]      dec_op;
  logic            dec_illegal;
  logic [XLEN-1:0] alu_res;
  logic [SHW-1:0]  shamt;
  logic            accept;

`ifdef ALU_MUL_EN
  logic            dec_mul;
  logic [SHW-1:0]  cnt;
  logic [XLEN-1:0] acc;
  logic [XLEN-1:0] mcand;
  logic [XLEN-1:0] mplier;
  logic [XLEN-1:0] acc_next;

  // Shift-and-add step: multiplicand moves left, multiplier right, one bit per cycle.
  assign acc_next = acc + (mplier[0] ? mcand : '0);
`endif

  assign in_ready = (state == S_IDLE) || (state == S_DONE && out_ready);
  assign accept   = in_valid && in_ready;
  assign shamt    = op_b[SHW-1:0];

  // alu_op has priority; only R-type consults funct7/funct3.
  always_comb begin
    dec_op      = OP_ADD;
    dec_illegal = 1'b0;
`ifdef ALU_MUL_EN
    dec_mul     = 1'b0;
`endif
    case (alu_op)
      2'b00: dec_op = OP_ADD;
      2'b11: dec_op = OP_PASS;
      2'b01: dec_op = OP_SUB;
      default: begin
        case ({funct7, funct3})
          10'b0000000_000: dec_op = OP_ADD;
          10'b0100000_000: dec_op = OP_SUB;
          10'b0000000_111: dec_op = OP_AND;
          10'b0000000_110: dec_op = OP_OR;
          10'b0000000_100: dec_op = OP_XOR;
          10'b0000000_001: dec_op = OP_SLL;
          10'b0000000_101: dec_op = OP_SRL;
          10'b0100000_101: dec_op = OP_SRA;
          10'b0000000_010: dec_op = OP_SLT;
          10'b0000000_011: dec_op = OP_SLTU;
`ifdef ALU_MUL_EN
          10'b0000001_000: begin
            dec_op  = OP_MUL;
            dec_mul = 1'b1;
          end
`endif
          default: begin
            dec_op      = OP_AND;
            dec_illegal = 1'b1;
          end
        endcase
      end
    endcase
  end

  // Illegal shares code 0000 with AND, so it is forced to zero explicitly.
  always_comb begin
    alu_res = '0;
    if (!dec_illegal) begin
      case (dec_op)
        OP_AND:  alu_res = op_a & op_b;
        OP_OR:   alu_res = op_a | op_b;
        OP_ADD:  alu_res = op_a + op_b;
        OP_SUB:  alu_res = op_a - op_b;
        OP_XOR:  alu_res = op_a ^ op_b;
        OP_SLL:  alu_res = op_a << shamt;
        OP_SRL:  alu_res = op_a >> shamt;
        OP_SRA:  alu_res = $unsigned($signed(op_a) >>> shamt);
        OP_PASS: alu_res = op_b;
        OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
        OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
        default: alu_res = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b1;
      operation <= 4'b0000;
      illegal   <= 1'b0;
`ifdef ALU_MUL_EN
      cnt       <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            state     <= S_DONE;
            out_valid <= 1'b1;
            result    <= alu_res;
            zero      <= (alu_res == '0);
            operation <= dec_op;
            illegal   <= dec_illegal;
`ifdef ALU_MUL_EN
            // A multiply overrides the single-cycle path; operands are latched here.
            if (dec_mul) begin
              state     <= S_MUL;
              out_valid <= 1'b0;
              cnt       <= '0;
              acc       <= '0;
              mcand     <= op_a;
              mplier    <= op_b;
            end
`endif
          end else if (state == S_DONE && out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
          end
        end
`ifdef ALU_MUL_EN
        S_MUL: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == SHW'(XLEN-1)) begin
            state     <= S_DONE;
            out_valid <= 1'b1;
            result    <= acc_next;
            zero      <= (acc_next == '0);
          end
        end
`endif
        default: begin
          state     <= S_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - table-driven and sequence checks for alu_exec_unit

module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  alu_op;
  logic [6:0]  funct7;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic [3:0]  operation;
  logic        illegal;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_exec_unit #(.XLEN(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .funct7    (funct7),
    .funct3    (funct3),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .operation (operation),
    .illegal   (illegal)
  );

  typedef struct {
    logic [1:0]  alu_op;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    logic [3:0]  exp_op;
    logic        exp_ill;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1;
    alu_op   = op;
    funct7   = f7;
    funct3   = f3;
    op_a     = a;
    op_b     = b;
  endtask

  initial begin
    vecs[0]  = '{2'b10, 7'b0000000, 3'b000, 32'd5,        32'd7,        32'd12,       4'b0010, 1'b0};
    vecs[1]  = '{2'b01, 7'b0000000, 3'b000, 32'h1234,     32'h1234,     32'h0,        4'b0110, 1'b0};
    vecs[2]  = '{2'b11, 7'b0000000, 3'b000, 32'h55,       32'hABCD0000, 32'hABCD0000, 4'b1000, 1'b0};
    vecs[3]  = '{2'b10, 7'b0100000, 3'b101, 32'h80000000, 32'h24,       32'hF8000000, 4'b0111, 1'b0};
    vecs[4]  = '{2'b10, 7'b0000000, 3'b011, 32'hFFFFFFFF, 32'h1,        32'h0,        4'b1010, 1'b0};
    vecs[5]  = '{2'b10, 7'b0000000, 3'b010, 32'hFFFFFFFF, 32'h1,        32'h1,        4'b1001, 1'b0};
    vecs[6]  = '{2'b00, 7'b0100000, 3'b111, 32'd100,      32'hFFFFFFFC, 32'd96,       4'b0010, 1'b0};
    vecs[7]  = '{2'b10, 7'b0100000, 3'b000, 32'd3,        32'd5,        32'hFFFFFFFE, 4'b0110, 1'b0};
    vecs[8]  = '{2'b10, 7'b0000000, 3'b111, 32'hF0F0,     32'hFF00,     32'hF000,     4'b0000, 1'b0};
    vecs[9]  = '{2'b10, 7'b0000000, 3'b110, 32'hF0F0,     32'hFF00,     32'hFFF0,     4'b0001, 1'b0};
    vecs[10] = '{2'b10, 7'b0000000, 3'b100, 32'hF0F0,     32'hFF00,     32'h0FF0,     4'b0100, 1'b0};
    vecs[11] = '{2'b10, 7'b0000000, 3'b001, 32'h1,        32'h21,       32'h2,        4'b0011, 1'b0};
    vecs[12] = '{2'b10, 7'b0000000, 3'b101, 32'h80000000, 32'h1F,       32'h1,        4'b0101, 1'b0};
    vecs[13] = '{2'b10, 7'b0100000, 3'b111, 32'h12,       32'h34,       32'h0,        4'b0000, 1'b1};
    vecs[14] = '{2'b10, 7'b0000000, 3'b000, 32'hFFFFFFFF, 32'h1,        32'h0,        4'b0010, 1'b0};
    vecs[15] = '{2'b01, 7'b1111111, 3'b111, 32'd10,       32'd3,        32'd7,        4'b0110, 1'b0};

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    alu_op    = 2'b00;
    funct7    = 7'd0;
    funct3    = 3'd0;
    op_a      = 32'd0;
    op_b      = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result",    result,             32'd0);
    chk("rst_zero",      {31'd0, zero},      32'd1);
    chk("rst_operation", {28'd0, operation}, 32'd0);
    chk("rst_illegal",   {31'd0, illegal},   32'd0);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);

    // Back-to-back single-cycle vectors with out_ready held high.
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].alu_op, vecs[i].f7, vecs[i].f3, vecs[i].a, vecs[i].b);
      #1;
      chk($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      chk($sformatf("v%0d_out_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("v%0d_result", i),    result,             vecs[i].exp_res);
      chk($sformatf("v%0d_operation", i), {28'd0, operation}, {28'd0, vecs[i].exp_op});
      chk($sformatf("v%0d_zero", i),      {31'd0, zero},      {31'd0, (vecs[i].exp_res == 32'd0)});
      chk($sformatf("v%0d_illegal", i),   {31'd0, illegal},   {31'd0, vecs[i].exp_ill});
    end
    @(negedge clk);
    chk("idle_after_vecs", {31'd0, out_valid}, 32'd0);

    // Multiply encoding: iterative with the macro, illegal single-cycle without.
    drive(2'b10, 7'b0000001, 3'b000, 32'hFFFFFFFF, 32'd3);
    @(negedge clk);
`ifdef ALU_MUL_EN
    // Conflicting request held during MUL must be ignored.
    drive(2'b11, 7'd0, 3'd0, 32'd0, 32'h11111111);
    begin
      int bad = 0;
      for (int k = 0; k < 32; k++) begin
        if (out_valid !== 1'b0 || in_ready !== 1'b0) bad++;
        @(negedge clk);
      end
      in_valid = 1'b0;
      chk("mul_busy_cycles_bad", bad, 32'd0);
    end
    chk("mul_out_valid", {31'd0, out_valid}, 32'd1);
    chk("mul_result",    result,             32'hFFFFFFFD);
    chk("mul_operation", {28'd0, operation}, 32'hC);
    chk("mul_illegal",   {31'd0, illegal},   32'd0);
`else
    in_valid = 1'b0;
    chk("mul_dis_out_valid", {31'd0, out_valid}, 32'd1);
    chk("mul_dis_result",    result,             32'd0);
    chk("mul_dis_illegal",   {31'd0, illegal},   32'd1);
    chk("mul_dis_operation", {28'd0, operation}, 32'd0);
    chk("mul_dis_zero",      {31'd0, zero},      32'd1);
`endif
    @(negedge clk);

    // Backpressure: ADD 1+1 held for 5 cycles, then SUB 9-4 accepted on release.
    out_ready = 1'b0;
    drive(2'b10, 7'd0, 3'b000, 32'd1, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    begin
      int bad = 0;
      for (int k = 0; k < 5; k++) begin
        if (out_valid !== 1'b1 || result !== 32'd2 || in_ready !== 1'b0) bad++;
        @(negedge clk);
      end
      chk("bp_hold_bad", bad, 32'd0);
    end
    chk("bp_result_held", result, 32'd2);
    out_ready = 1'b1;
    drive(2'b10, 7'b0100000, 3'b000, 32'd9, 32'd4);
    #1;
    chk("bp_in_ready_release", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_sub_valid",  {31'd0, out_valid}, 32'd1);
    chk("bp_sub_result", result,             32'd5);
    chk("bp_sub_op",     {28'd0, operation}, 32'h6);
    @(negedge clk);
    chk("bp_idle", {31'd0, out_valid}, 32'd0);

    // Reset during a long operation (MUL with the macro, held DONE without).
`ifdef ALU_MUL_EN
    drive(2'b10, 7'b0000001, 3'b000, 32'd6, 32'd7);
`else
    out_ready = 1'b0;
    drive(2'b10, 7'd0, 3'b000, 32'd6, 32'd7);
`endif
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    chk("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_mid_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_mid_result",    result,             32'd0);
    drive(2'b10, 7'd0, 3'b000, 32'd3, 32'd4);
    @(negedge clk);
    in_valid = 1'b0;
    chk("post_rst_valid",  {31'd0, out_valid}, 32'd1);
    chk("post_rst_result", result,             32'd7);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Parametrised successor to the combinational ALU-control decode.
- Decodes ALUOp/funct7/funct3 into a 4-bit operation code, executes the operation on XLEN-bit operands and returns a registered result.
- Uses a valid/ready handshake on both input and output.
- Single-cycle ops complete in 1 cycle; optional RV32M-style MUL (low word) runs iteratively over XLEN cycles.
- Sits in the EX stage between operand muxes and the writeback/branch logic.

Parameters:
- XLEN, 32, operand/result width; power of 2, >= 8.
- SHW, $clog2(XLEN), shift-amount width (derived; do not override).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  request valid
- in_ready  output  1  unit can accept a request this cycle
- alu_op  input  2  00 load/store, 01 branch, 10 R-type, 11 LUI
- funct7  input  7  instruction funct7
- funct3  input  3  instruction funct3
- op_a  input  XLEN  operand A
- op_b  input  XLEN  operand B / U-immediate
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- result  output  XLEN  registered result
- zero  output  1  result == 0 (registered alongside result)
- operation  output  4  decoded op code of the held result
- illegal  output  1  held request had an unrecognised R-type encoding

Behaviour:
- Decode, alu_op priority:
  - 00 -> ADD 0010
  - 11 -> PASS_B 1000
  - 01 -> SUB 0110
  - 10 -> table by {funct7, funct3}:
    - 0000000/000 ADD 0010; 0100000/000 SUB 0110
    - 0000000/111 AND 0000; 0000000/110 OR 0001
    - 0000000/100 XOR 0100; 0000000/001 SLL 0011
    - 0000000/101 SRL 0101; 0100000/101 SRA 0111
    - 0000000/010 SLT 1001; 0000000/011 SLTU 1010
    - 0000001/000 MUL 1100 (only with the macro)
  - Any other R-type encoding -> operation 0000, illegal=1, result 0.
- Arithmetic:
  - Add/sub are modulo 2^XLEN.
  - Shifts use op_b[SHW-1:0] only.
  - SLT is signed; SLTU is unsigned; both yield 0 or 1 zero-extended.
  - MUL returns the low XLEN bits of op_a*op_b.
- FSM states IDLE, MUL, DONE:
  - in_ready = (state==IDLE) || (state==DONE && out_ready).
  - Accept on in_valid && in_ready.
  - Non-MUL accepted -> DONE next cycle with result/zero/operation/illegal registered; out_valid=1.
  - MUL accepted -> MUL state, iteration counter=0, accumulator=0.
  - MUL state: each cycle adds the shifted multiplicand if the current multiplier bit is 1, then shifts. When the counter reaches XLEN-1, go to DONE.
  - MUL latency: out_valid rises exactly XLEN cycles after the accept edge (32 for default).
  - DONE: outputs held stable while out_ready=0. On out_ready=1:
    - new request accepted the same cycle -> back-to-back: DONE for a single-cycle op, MUL for a multiply.
    - no new request -> IDLE.
  - In MUL, in_ready=0; inputs are ignored (operands latched at accept).
- Reset:
  - Values: state=IDLE, out_valid=0, result=0, zero=1, operation=0000, illegal=0, counter=0.
  - Reset mid-MUL or in DONE aborts and discards the result; in_ready=1 the cycle after reset deasserts.
- zero is computed from the final result, including for illegal ops (zero=1).

Optional Feature:
- ALU_MUL_EN defined: MUL encoding decoded and executed as above.
- ALU_MUL_EN undefined: 0000001/000 treated as illegal (illegal=1, result 0, 1-cycle latency); MUL state and multiplier datapath not synthesised.

Test Plan:
1. Reset then alu_op=10, funct7=0000000, funct3=000, A=5, B=7, out_ready=1 -> next cycle out_valid=1, result=12, operation=0010, zero=0.
2. alu_op=01, A=B=0x1234 -> result=0, zero=1, operation=0110. Then alu_op=11, B=0xABCD0000 -> result=0xABCD0000, operation=1000.
3. SRA: funct7=0100000, funct3=101, A=0x80000000, B=0x24 (shamt 4) -> 0xF8000000. SLTU with A=0xFFFFFFFF, B=1 -> 0; SLT with the same operands -> 1.
4. With ALU_MUL_EN: MUL A=0xFFFFFFFF, B=3 -> in_ready=0 for 32 cycles, out_valid at cycle 32, result=0xFFFFFFFD. Without the macro: illegal=1, result=0 after 1 cycle.
5. Backpressure: hold out_ready=0 for 5 cycles after ADD 1+1 -> result stays 2, in_ready=0. Raise out_ready with a new valid SUB 9-4 -> accepted the same cycle, result 5 on the next cycle.
6. Assert reset 10 cycles into a MUL -> out_valid=0 and state IDLE after reset; the following ADD 3+4 returns 7 with 1-cycle latency.
